// File: rtl/implication_commit_if.sv
// Handshake bundle between the implication engine, the commit block and the assignment store.
interface implication_commit_if #(
    parameter int unsigned LUT_SIZE     = 8,
    parameter int unsigned VAR_ID_WIDTH = 20
);
    localparam int unsigned PIN_W = 2 * LUT_SIZE + 2;
    localparam int unsigned IDS_W = (LUT_SIZE + 1) * VAR_ID_WIDTH;
    localparam int unsigned CNT_W = $clog2(LUT_SIZE + 2);

    logic                    in_valid;
    logic                    in_ready;
    logic [PIN_W-1:0]        in_pins;
    logic [PIN_W-1:0]        in_implied;
    logic                    in_conflict;
    logic [IDS_W-1:0]        in_var_ids;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [VAR_ID_WIDTH-1:0] wr_var_id;
    logic                    wr_value;
    logic                    done_valid;
    logic                    done_ready;
    logic [CNT_W-1:0]        done_count;
    logic                    done_conflict;

    modport master (
        output in_valid, in_pins, in_implied, in_conflict, in_var_ids, wr_ready, done_ready,
        input  in_ready, wr_valid, wr_var_id, wr_value, done_valid, done_count, done_conflict
    );

    modport slave (
        input  in_valid, in_pins, in_implied, in_conflict, in_var_ids, wr_ready, done_ready,
        output in_ready, wr_valid, wr_var_id, wr_value, done_valid, done_count, done_conflict
    );
endinterface

// File: rtl/implication_commit.sv
// Serialises newly implied LUT pins onto the assignment write port and reports a per-LUT record.
// Optional IMPLY_COMMIT_DUPVAR_EN: merge/flag pins that share a variable ID (adds one cycle).
module implication_commit #(
    parameter int unsigned LUT_SIZE     = 8,
    parameter int unsigned VAR_ID_WIDTH = 20
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    implication_commit_if.slave bus
);
    localparam int unsigned NP    = LUT_SIZE + 1;
    localparam int unsigned CNT_W = $clog2(LUT_SIZE + 2);
    localparam int unsigned IDS_W = NP * VAR_ID_WIDTH;

    localparam logic [1:0] ZERO = 2'b00;
    localparam logic [1:0] ONE  = 2'b01;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EMIT   = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;
`ifdef IMPLY_COMMIT_DUPVAR_EN
    localparam logic [1:0] DEDUP  = 2'd3;
`endif

    function automatic logic is_known(input logic [1:0] p);
        return (p == ZERO) || (p == ONE);
    endfunction

    logic [1:0]       state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [NP-1:0]    mask_q, mask_d;
    logic [NP-1:0]    val_q, val_d;
    logic [IDS_W-1:0] ids_q, ids_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             conflict_q, conflict_d;

    logic [NP-1:0]    new_mask, new_val, known_mask, known_val, lowest;
    logic             base_conf, accept;

    // Classify each pin of the incoming result
    always_comb begin
        new_mask   = '0;
        new_val    = '0;
        known_mask = '0;
        known_val  = '0;
        base_conf  = bus.in_conflict;
        for (int i = 0; i < int'(NP); i++) begin
            known_mask[i] = is_known(bus.in_pins[2*i +: 2]);
            known_val[i]  = bus.in_pins[2*i];
            new_mask[i]   = !is_known(bus.in_pins[2*i +: 2]) && is_known(bus.in_implied[2*i +: 2]);
            new_val[i]    = bus.in_implied[2*i];
            if (is_known(bus.in_pins[2*i +: 2]) && (bus.in_implied[2*i +: 2] != bus.in_pins[2*i +: 2]))
                base_conf = 1'b1;
        end
    end

`ifdef IMPLY_COMMIT_DUPVAR_EN
    logic [NP-1:0] drop_q, drop_d, dup_drop;
    logic          dupconf_q, dupconf_d, dup_conf;

    // Pairwise ID compare; a higher pin repeating a lower pin's assignment is redundant
    always_comb begin
        dup_drop = '0;
        dup_conf = 1'b0;
        for (int i = 0; i < int'(NP); i++) begin
            for (int j = 0; j < int'(NP); j++) begin
                if (j != i && bus.in_var_ids[i*VAR_ID_WIDTH +: VAR_ID_WIDTH]
                              == bus.in_var_ids[j*VAR_ID_WIDTH +: VAR_ID_WIDTH]) begin
                    if (new_mask[i] && new_mask[j] && j < i) begin
                        if (new_val[i] == new_val[j]) dup_drop[i] = 1'b1;
                        else                          dup_conf    = 1'b1;
                    end
                    if (new_mask[i] && known_mask[j] && new_val[i] != known_val[j])
                        dup_conf = 1'b1;
                end
            end
        end
    end
`endif

    assign accept = (state_q == IDLE) && in_ready_q && bus.in_valid;
    assign lowest = mask_q & (~mask_q + NP'(1));

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        val_d      = val_q;
        ids_d      = ids_q;
        count_d    = count_q;
        conflict_d = conflict_q;
`ifdef IMPLY_COMMIT_DUPVAR_EN
        drop_d     = drop_q;
        dupconf_d  = dupconf_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ids_d      = bus.in_var_ids;
                    val_d      = new_val;
                    count_d    = '0;
                    conflict_d = base_conf;
`ifdef IMPLY_COMMIT_DUPVAR_EN
                    mask_d     = new_mask;
                    drop_d     = dup_drop;
                    dupconf_d  = dup_conf;
                    state_d    = DEDUP;
`else
                    mask_d     = base_conf ? '0 : new_mask;
                    state_d    = (base_conf || new_mask == '0) ? REPORT : EMIT;
`endif
                end
            end
`ifdef IMPLY_COMMIT_DUPVAR_EN
            DEDUP: begin
                conflict_d = conflict_q || dupconf_q;
                mask_d     = (conflict_q || dupconf_q) ? '0 : (mask_q & ~drop_q);
                state_d    = (mask_d == '0) ? REPORT : EMIT;
            end
`endif
            EMIT: begin
                if (bus.wr_ready) begin
                    mask_d  = mask_q & ~lowest;
                    count_d = count_q + CNT_W'(1);
                    if (mask_d == '0) state_d = REPORT;
                end
            end
            REPORT: begin
                if (bus.done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    // State and latched-result registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            mask_q     <= '0;
            val_q      <= '0;
            ids_q      <= '0;
            count_q    <= '0;
            conflict_q <= 1'b0;
`ifdef IMPLY_COMMIT_DUPVAR_EN
            drop_q     <= '0;
            dupconf_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            mask_q     <= mask_d;
            val_q      <= val_d;
            ids_q      <= ids_d;
            count_q    <= count_d;
            conflict_q <= conflict_d;
`ifdef IMPLY_COMMIT_DUPVAR_EN
            drop_q     <= drop_d;
            dupconf_q  <= dupconf_d;
`endif
        end
    end

    // Lowest pending pin drives the write port; zero when nothing is pending
    always_comb begin
        bus.wr_var_id = '0;
        bus.wr_value  = 1'b0;
        for (int i = int'(NP) - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                bus.wr_var_id = ids_q[i*VAR_ID_WIDTH +: VAR_ID_WIDTH];
                bus.wr_value  = val_q[i];
            end
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.wr_valid      = (state_q == EMIT);
    assign bus.done_valid    = (state_q == REPORT);
    assign bus.done_count    = count_q;
    assign bus.done_conflict = conflict_q;
endmodule

// File: tb/tb_implication_commit.sv
// Directed self-checking bench for implication_commit (default or IMPLY_COMMIT_DUPVAR_EN build).
module tb_implication_commit;
    localparam int unsigned LS = 8;
    localparam int unsigned VW = 20;
    localparam int unsigned NP = LS + 1;
    localparam int unsigned PW = 2 * LS + 2;
`ifdef IMPLY_COMMIT_DUPVAR_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    implication_commit_if #(.LUT_SIZE(LS), .VAR_ID_WIDTH(VW)) bus();
    implication_commit #(.LUT_SIZE(LS), .VAR_ID_WIDTH(VW)) dut (
        .ap_clk  (clk),
        .ap_rst_n(rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [PW-1:0]          p, im;
    logic [NP-1:0][VW-1:0]  ids;
    logic [VW-1:0]          exp_id [10];
    logic                   exp_val[10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_vec();
        p   = '1;
        im  = '1;
        ids = '0;
    endtask

    task automatic send(input logic c);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_pins     = p;
        bus.in_implied  = im;
        bus.in_conflict = c;
        bus.in_var_ids  = ids;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.in_conflict = 1'b0;
    endtask

    task automatic dedup_gap();
        if (DUP) begin
            @(negedge clk);
            chk("dedup_gap_wr_valid", 32'(bus.wr_valid), 32'd0);
            chk("dedup_gap_done_valid", 32'(bus.done_valid), 32'd0);
        end
    endtask

    task automatic expect_run(input string tag, input int n, input logic conf);
        dedup_gap();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_wr_valid"}, 32'(bus.wr_valid), 32'd1);
            chk({tag, "_wr_var_id"}, 32'(bus.wr_var_id), 32'(exp_id[i]));
            chk({tag, "_wr_value"}, 32'(bus.wr_value), 32'(exp_val[i]));
        end
        @(negedge clk);
        chk({tag, "_done_valid"}, 32'(bus.done_valid), 32'd1);
        chk({tag, "_done_count"}, 32'(bus.done_count), 32'(n));
        chk({tag, "_done_conflict"}, 32'(bus.done_conflict), 32'(conf));
        chk({tag, "_no_wr"}, 32'(bus.wr_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_done_dropped"}, 32'(bus.done_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_pins     = '0;
        bus.in_implied  = '0;
        bus.in_conflict = 1'b0;
        bus.in_var_ids  = '0;
        bus.wr_ready    = 1'b1;
        bus.done_ready  = 1'b1;

        // Reset state
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        chk("rst_done_valid", 32'(bus.done_valid), 32'd0);
        chk("rst_wr_var_id", 32'(bus.wr_var_id), 32'd0);
        chk("rst_wr_value", 32'(bus.wr_value), 32'd0);
        chk("rst_done_count", 32'(bus.done_count), 32'd0);
        chk("rst_done_conflict", 32'(bus.done_conflict), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Two new pins, output pin last
        clear_vec();
        im[2*3 +: 2] = 2'b01; ids[3] = 20'h00005;
        im[2*8 +: 2] = 2'b00; ids[8] = 20'h00010;
        exp_id[0] = 20'h00005; exp_val[0] = 1'b1;
        exp_id[1] = 20'h00010; exp_val[1] = 1'b0;
        send(1'b0);
        expect_run("basic", 2, 1'b0);

        // Explicit conflict flag suppresses writes
        clear_vec();
        im[1:0] = 2'b01; ids[0] = 20'h00001;
        send(1'b1);
        expect_run("conflict_flag", 0, 1'b1);

        // Known pin contradicted by implication
        clear_vec();
        p[2*2 +: 2] = 2'b00; im[2*2 +: 2] = 2'b01;
        im[1:0] = 2'b00;
        send(1'b0);
        expect_run("known_conflict", 0, 1'b1);

        // Backpressure on the second of three writes
        clear_vec();
        im[2*0 +: 2] = 2'b01; ids[0] = 20'h0000A;
        im[2*4 +: 2] = 2'b00; ids[4] = 20'h0000B;
        im[2*8 +: 2] = 2'b01; ids[8] = 20'h0000C;
        send(1'b0);
        dedup_gap();
        @(negedge clk);
        chk("bp_w0_valid", 32'(bus.wr_valid), 32'd1);
        chk("bp_w0_id", 32'(bus.wr_var_id), 32'h0000A);
        chk("bp_w0_val", 32'(bus.wr_value), 32'd1);
        @(negedge clk);
        chk("bp_w1_id", 32'(bus.wr_var_id), 32'h0000B);
        bus.wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_stall_valid", 32'(bus.wr_valid), 32'd1);
            chk("bp_stall_id", 32'(bus.wr_var_id), 32'h0000B);
            chk("bp_stall_val", 32'(bus.wr_value), 32'd0);
        end
        bus.wr_ready = 1'b1;
        @(negedge clk);
        chk("bp_w2_id", 32'(bus.wr_var_id), 32'h0000C);
        chk("bp_w2_val", 32'(bus.wr_value), 32'd1);
        @(negedge clk);
        chk("bp_done_valid", 32'(bus.done_valid), 32'd1);
        chk("bp_done_count", 32'(bus.done_count), 32'd3);
        chk("bp_done_conflict", 32'(bus.done_conflict), 32'd0);
        @(negedge clk);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd1);

        // Nothing new: report held under done backpressure
        clear_vec();
        p[2*0 +: 2] = 2'b00;
        p[2*5 +: 2] = 2'b01;
        im = p;
        bus.done_ready = 1'b0;
        send(1'b0);
        dedup_gap();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("empty_done_valid", 32'(bus.done_valid), 32'd1);
            chk("empty_done_count", 32'(bus.done_count), 32'd0);
            chk("empty_done_conflict", 32'(bus.done_conflict), 32'd0);
            chk("empty_in_ready", 32'(bus.in_ready), 32'd0);
            chk("empty_wr_valid", 32'(bus.wr_valid), 32'd0);
        end
        bus.done_ready = 1'b1;
        @(negedge clk);
        chk("empty_released", 32'(bus.done_valid), 32'd0);
        chk("empty_in_ready_back", 32'(bus.in_ready), 32'd1);

        // Every pin new: maximum count
        clear_vec();
        for (int i = 0; i < int'(NP); i++) begin
            im[2*i +: 2] = (i % 2 == 1) ? 2'b01 : 2'b00;
            ids[i]       = VW'(32'h100 + i);
            exp_id[i]    = VW'(32'h100 + i);
            exp_val[i]   = (i % 2 == 1);
        end
        send(1'b0);
        expect_run("all_pins", 9, 1'b0);

        // Shared variable, same value
        clear_vec();
        im[2*1 +: 2] = 2'b01; ids[1] = 20'h00007;
        im[2*2 +: 2] = 2'b01; ids[2] = 20'h00007;
        exp_id[0] = 20'h00007; exp_val[0] = 1'b1;
        exp_id[1] = 20'h00007; exp_val[1] = 1'b1;
        send(1'b0);
        expect_run("dup_same", DUP ? 1 : 2, 1'b0);

        // Shared variable, opposite values
        clear_vec();
        im[2*1 +: 2] = 2'b01; ids[1] = 20'h00007;
        im[2*2 +: 2] = 2'b00; ids[2] = 20'h00007;
        exp_id[0] = 20'h00007; exp_val[0] = 1'b1;
        exp_id[1] = 20'h00007; exp_val[1] = 1'b0;
        send(1'b0);
        expect_run("dup_diff", DUP ? 0 : 2, DUP);

        // Asynchronous reset in the middle of a write burst
        clear_vec();
        im[2*1 +: 2] = 2'b01; ids[1] = 20'h00021;
        im[2*2 +: 2] = 2'b01; ids[2] = 20'h00022;
        im[2*3 +: 2] = 2'b01; ids[3] = 20'h00023;
        im[2*6 +: 2] = 2'b01; ids[6] = 20'h00024;
        send(1'b0);
        dedup_gap();
        @(negedge clk);
        chk("rst_mid_w0_id", 32'(bus.wr_var_id), 32'h00021);
        @(negedge clk);
        chk("rst_mid_w1_id", 32'(bus.wr_var_id), 32'h00022);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_valid", 32'(bus.wr_valid), 32'd0);
        chk("rst_mid_done_valid", 32'(bus.done_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mid_wr_var_id", 32'(bus.wr_var_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready_back", 32'(bus.in_ready), 32'd1);
        chk("rst_mid_no_resume", 32'(bus.wr_valid), 32'd0);

        // Clean LUT after the abort: output pin only, maximum ID
        clear_vec();
        im[2*8 +: 2] = 2'b01; ids[8] = 20'hFFFFF;
        exp_id[0] = 20'hFFFFF; exp_val[0] = 1'b1;
        send(1'b0);
        expect_run("post_abort", 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
